// File: rtl/seven_seg_pkg.sv
// Shared segment codes, FSM states and sizing helpers for the signed
// 7-segment display path.
package seven_seg_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    function automatic logic [7:0] digit_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Decimal digits needed for the largest magnitude, 2^(bits-1).
    function automatic int bcd_digits(input int bits);
        longint v;
        int     n;
        v = longint'(1) << (bits - 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 0) begin
                n = n + 1;
                v = v / 10;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/seven_seg_bin2bcd.sv
// Sequential double-dabble: one magnitude bit per clock, BITS clocks per
// conversion. o_done marks the cycle whose edge performs the final shift.
module bin2bcd
    import seven_seg_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int BCD_W = 4 * bcd_digits(BITS)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_start,
    input  logic [BITS-1:0]  i_mag,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);

    localparam int CW = $clog2(BITS + 1);

    logic [BITS-1:0]  r_mag;
    logic [BCD_W-1:0] r_bcd;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic [BCD_W-1:0] w_bcd_adj;
    logic             w_last;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                          r_bcd[gi*4 +: 4] + 4'd3 : r_bcd[gi*4 +: 4];
        end
    endgenerate

    assign w_last = (r_cnt == CW'(BITS - 1));
    assign o_done = r_busy & w_last;
    assign o_bcd  = r_bcd;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_mag  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_mag  <= i_mag;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_bcd <= {w_bcd_adj[BCD_W-2:0], r_mag[BITS-1]};
            r_mag <= {r_mag[BITS-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seven_seg_display.sv
// Signed value to multiplexed common-anode 7-segment bank: sign/magnitude
// capture, BCD conversion, display register with blanking, digit scan.
module seven_seg_display
    import seven_seg_pkg::*;
#(
    parameter int BITS           = 16,
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BITS-1:0]       value_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [7:0]            cathode
);

    localparam int BCD_DIGITS = bcd_digits(BITS);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int RW         = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    generate
        if (NUM_DIGITS < BCD_DIGITS + 1) begin : g_chk_digits
            $error("NUM_DIGITS too small for BITS plus a sign digit");
        end
        if (REFRESH_CYCLES < 1) begin : g_chk_refresh
            $error("REFRESH_CYCLES must be at least 1");
        end
    endgenerate

    state_t                r_state;
    logic                  r_ready;
    logic                  r_sign;
    logic [BCD_W-1:0]      r_disp_bcd;
    logic                  r_disp_neg;
    logic [RW-1:0]         r_refresh;
    logic [IW-1:0]         r_index;
    logic [NUM_DIGITS-1:0] r_anode;
    logic [7:0]            r_cathode;

    logic                  w_start;
    logic                  w_done;
    logic [BITS-1:0]       w_mag;
    logic [BCD_W-1:0]      w_bcd;
    logic [BCD_W-1:0]      w_disp_bcd_next;
    logic                  w_disp_neg_next;
    logic                  w_wrap;
    logic [IW-1:0]         w_index_next;
    logic [NUM_DIGITS-1:0] w_anode_next;
    logic [7:0]            w_seg [NUM_DIGITS];
    int                    w_msd;

    assign w_start   = valid_in & r_ready;
    assign w_mag     = value_in[BITS-1] ? (~value_in) + BITS'(1) : value_in;
    assign ready_out = r_ready;
    assign anode     = r_anode;
    assign cathode   = r_cathode;

    bin2bcd #(.BITS(BITS), .BCD_W(BCD_W)) u_bin2bcd (
        .clk     (clk),
        .srst    (rst),
        .i_start (w_start),
        .i_mag   (w_mag),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_sign  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_state <= CONVERT;
                    r_ready <= 1'b0;
                    r_sign  <= value_in[BITS-1];
                end
                CONVERT: if (w_done) r_state <= LOAD;
                LOAD: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Segments are derived from next-state display and index so anode and
    // cathode always describe the same digit of the same value.
    assign w_disp_bcd_next = rst ? '0 : (r_state == LOAD) ? w_bcd : r_disp_bcd;
    assign w_disp_neg_next = rst ? 1'b0 : (r_state == LOAD) ? r_sign : r_disp_neg;

    always_comb begin
        w_msd = 0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (w_disp_bcd_next[i*4 +: 4] != 4'd0) w_msd = i;
        end
    end

    assign w_wrap       = (r_refresh == RW'(REFRESH_CYCLES - 1));
    assign w_index_next = rst ? '0 :
                          !w_wrap ? r_index :
                          (r_index == IW'(NUM_DIGITS - 1)) ? '0 : r_index + IW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_anode_next[gi] = (w_index_next != IW'(gi));
            if (gi < BCD_DIGITS) begin : g_num
                assign w_seg[gi] = (gi <= w_msd) ? digit_to_seg(w_disp_bcd_next[gi*4 +: 4]) :
                                   (w_disp_neg_next && gi == w_msd + 1) ? SEG_MINUS : SEG_BLANK;
            end else begin : g_sign_only
                assign w_seg[gi] = (w_disp_neg_next && gi == w_msd + 1) ? SEG_MINUS : SEG_BLANK;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        r_disp_bcd <= w_disp_bcd_next;
        r_disp_neg <= w_disp_neg_next;
        r_index    <= w_index_next;
        r_anode    <= w_anode_next;
        r_cathode  <= w_seg[w_index_next];
        if (rst || w_wrap) begin
            r_refresh <= '0;
        end else begin
            r_refresh <= r_refresh + RW'(1);
        end
    end

endmodule

// File: tb/tb_seven_seg_display.sv
// Directed bench for seven_seg_display with a cycle-level behavioural model
// checked every clock, plus literal digit expectations per scenario.
module tb_seven_seg_display;

    localparam int BITS = 16;
    localparam int ND   = 8;
    localparam int RC   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [BITS-1:0] value_in = '0;
    logic            valid_in = 1'b0;
    logic            ready_out;
    logic [ND-1:0]   anode;
    logic [7:0]      cathode;

    seven_seg_display #(.BITS(BITS), .NUM_DIGITS(ND), .REFRESH_CYCLES(RC)) dut (
        .clk       (clk),
        .rst       (rst),
        .value_in  (value_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .anode     (anode),
        .cathode   (cathode)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Model state: what the display shows, where the scan is, and how many
    // clocks remain before a pending value reaches the display.
    int m_disp  = 0;
    int m_pend  = 0;
    int m_busy  = 0;
    int m_ref   = 0;
    int m_idx   = 0;
    bit m_valid = 0;

    function automatic logic [7:0] exp_seg(input int val, input int pos);
        int mag;
        int d [10];
        int msd;
        mag = (val < 0) ? -val : val;
        msd = 0;
        for (int i = 0; i < 10; i++) begin
            d[i] = mag % 10;
            mag  = mag / 10;
            if (d[i] != 0) msd = i;
        end
        if (pos <= msd) return seg_tab[d[pos]];
        if (val < 0 && pos == msd + 1) return 8'hBF;
        return 8'hFF;
    endfunction

    function automatic logic [ND-1:0] exp_anode(input int idx);
        logic [ND-1:0] one;
        one = 1;
        return ~(one << idx);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [BITS-1:0] val);
        if (r) begin
            m_disp = 0; m_busy = 0; m_ref = 0; m_idx = 0; m_valid = 1;
        end else begin
            if (m_ref == RC - 1) begin
                m_ref = 0;
                m_idx = (m_idx + 1) % ND;
            end else begin
                m_ref++;
            end
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_disp = m_pend;
            end else if (v) begin
                m_pend = int'($signed(val));
                m_busy = BITS + 1;
            end
        end
    endtask

    // One clock: drive, let the edge happen, advance model, compare on the falling edge.
    task automatic cycle(input logic v, input logic [BITS-1:0] val, input logic r);
        valid_in = v;
        value_in = val;
        rst      = r;
        @(posedge clk);
        model_step(r, v, val);
        @(negedge clk);
        if (m_valid) begin
            chk("model_ready", {31'd0, ready_out}, {31'd0, m_busy == 0});
            chk("model_anode", {24'd0, anode}, {24'd0, exp_anode(m_idx)});
            chk("model_cathode", {24'd0, cathode}, {24'd0, exp_seg(m_disp, m_idx)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready_out && n < 40) begin
            cycle(1'b0, '0, 1'b0);
            n++;
        end
        chk("wait_ready_timeout", {31'd0, ready_out}, 32'd1);
    endtask

    task automatic check_digit(input string name, input int k, input logic [7:0] exp);
        int n;
        n = 0;
        while (anode !== exp_anode(k) && n < 40) begin
            cycle(1'b0, '0, 1'b0);
            n++;
        end
        chk({name, "_anode"}, {24'd0, anode}, {24'd0, exp_anode(k)});
        chk(name, {24'd0, cathode}, {24'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lowcnt;
        logic [7:0] e1234 [6] = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF, 8'hFF};
        logic [7:0] emin  [6] = '{8'h80, 8'h82, 8'hF8, 8'hA4, 8'hB0, 8'hBF};
        logic [7:0] emax  [6] = '{8'hF8, 8'h82, 8'hF8, 8'hA4, 8'hB0, 8'hFF};
        logic [7:0] e4321 [5] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'hFF};

        // Pin the model's digit function against hand-worked values.
        for (int k = 0; k < 6; k++) begin
            chk("model_pin_1234", {24'd0, exp_seg(1234, k)}, {24'd0, e1234[k]});
            chk("model_pin_min", {24'd0, exp_seg(-32768, k)}, {24'd0, emin[k]});
        end
        chk("model_pin_neg1_d1", {24'd0, exp_seg(-1, 1)}, 32'hBF);

        // Reset and scan
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("rst_anode", {24'd0, anode}, 32'hFE);
        chk("rst_cathode", {24'd0, cathode}, 32'hC0);
        chk("rst_ready", {31'd0, ready_out}, 32'd1);
        idle(4);
        chk("scan4_anode", {24'd0, anode}, 32'hFD);
        chk("scan4_cathode", {24'd0, cathode}, 32'hFF);
        idle(28);
        chk("scan32_anode", {24'd0, anode}, 32'hFE);

        // Positive value
        cycle(1'b1, 16'd1234, 1'b0);
        lowcnt = 0;
        while (!ready_out && lowcnt < 40) begin
            lowcnt++;
            cycle(1'b0, '0, 1'b0);
        end
        chk("busy_cycles_1234", lowcnt, 32'd17);
        for (int k = 0; k < 6; k++) check_digit("pos_1234", k, e1234[k]);
        check_digit("pos_1234_top", 7, 8'hFF);

        // Negative value
        cycle(1'b1, 16'hFFFF, 1'b0);
        wait_ready();
        check_digit("neg1_d0", 0, 8'hF9);
        check_digit("neg1_d1", 1, 8'hBF);
        check_digit("neg1_d2", 2, 8'hFF);

        // Extremes back to back
        cycle(1'b1, 16'h8000, 1'b0);
        wait_ready();
        for (int k = 0; k < 6; k++) check_digit("min_val", k, emin[k]);
        cycle(1'b1, 16'h7FFF, 1'b0);
        wait_ready();
        for (int k = 0; k < 6; k++) check_digit("max_val", k, emax[k]);

        // Busy: 9 offered throughout conversion of 5 is ignored
        cycle(1'b1, 16'd5, 1'b0);
        for (int i = 0; i < 17; i++) cycle(1'b1, 16'd9, 1'b0);
        chk("busy_ready_back", {31'd0, ready_out}, 32'd1);
        cycle(1'b1, 16'd9, 1'b0);
        chk("busy_9_accepted", {31'd0, ready_out}, 32'd0);
        wait_ready();
        check_digit("busy_9_d0", 0, 8'h90);
        check_digit("busy_9_d1", 1, 8'hFF);

        // Reset mid-conversion; valid during reset is discarded
        cycle(1'b1, 16'd4321, 1'b0);
        idle(8);
        cycle(1'b1, 16'd4321, 1'b1);
        chk("midrst_ready", {31'd0, ready_out}, 32'd1);
        idle(2);
        chk("midrst_still_ready", {31'd0, ready_out}, 32'd1);
        check_digit("midrst_d0", 0, 8'hC0);
        check_digit("midrst_d1", 1, 8'hFF);
        cycle(1'b1, 16'd4321, 1'b0);
        wait_ready();
        for (int k = 0; k < 5; k++) check_digit("after_rst_4321", k, e4321[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_display.md
Name: seven_seg_display

Overview:
- Display end of the switch/LED arithmetic path: takes a signed BITS-wide arithmetic result and shows it as signed decimal on a multiplexed, common-anode 7-segment bank.
- Binary to BCD conversion is a sequential double-dabble that processes one bit per clock.
- A refresh counter scans the digits continuously.
- Sits between the add/subtract datapath and the board's anode and cathode pins.

Parameters:
- BITS, 16, width of signed input value.
- NUM_DIGITS, 8, number of physical digits. Elaboration check: NUM_DIGITS >= BCD_DIGITS(BITS)+1.
- REFRESH_CYCLES, 100000, clocks each digit stays lit. Must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- value_in  input  BITS  signed value to display
- valid_in  input  1  value_in is offered this cycle
- ready_out  output  1  block accepts value_in this cycle
- anode  output  NUM_DIGITS  digit enables, active low, one-hot-low
- cathode  output  8  segments {dp,g,f,e,d,c,b,a}, active low

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. All state updates on rising clk.
- Reset values:
  - FSM = IDLE, ready_out = 1.
  - Display register = magnitude 0, sign positive.
  - digit index = 0, refresh counter = 0.
  - anode = all ones except bit0 = 0. cathode = 8'hC0 (digit "0").
- Handshake: a transfer occurs on an edge where valid_in & ready_out are both high. ready_out is 1 only in IDLE. valid_in while busy is ignored, not queued.
- FSM states:
  - IDLE -> CONVERT on transfer. Captures sign = value_in[BITS-1] and magnitude = |value_in| in BITS+1... BITS bits unsigned. The most negative value, -2^(BITS-1), yields magnitude 2^(BITS-1) with no overflow.
  - CONVERT: exactly BITS cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, mag} left by 1.
  - CONVERT -> LOAD after the BITS-th shift.
  - LOAD: one cycle. Copies BCD and sign into the display register. Goes to IDLE.
- Latency: transfer at edge N means the display register is updated at edge N+BITS+1, and ready_out is high again after edge N+BITS+1. The old value stays displayed throughout conversion (no flicker or blanking).
- Scan:
  - Refresh counter counts 0..REFRESH_CYCLES-1.
  - On wrap, digit index increments and wraps from NUM_DIGITS-1 to 0.
  - anode[index] = 0, all other anode bits = 1.
  - cathode is registered together with anode. Both change on the same edge, with no off-by-one digit.
- Digit content: index 0 is the least significant digit.
  - Leading-zero blanking: digits above the most significant nonzero BCD digit show blank (8'hFF).
  - A value of 0 shows "0" in digit 0.
  - Negative values show "-" (8'hBF) in the digit immediately above the most significant nonzero digit.
  - dp is always off (cathode[7] = 1).
- Segment codes (dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Reset mid-conversion: conversion is abandoned and the display register is cleared to 0. The next transfer after reset is processed normally.
- Boundary: a transfer in the same cycle as rst is discarded (reset wins).

Decomposition:
- Package seven_seg_pkg holds:
  - Segment constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK.
  - Function digit_to_seg(logic [3:0]) returning logic [7:0].
  - Constant function bcd_digits(bits), returning the number of decimal digits needed for 2^(bits-1).
  - FSM state enum {IDLE, CONVERT, LOAD}.
- Sub-module bin2bcd: the sequential double-dabble, with start/done handshake, parameter BITS, and a BCD output port.
- The top level owns the sign/magnitude capture, display register, blanking logic and scan.

Test Plan:
- Bench overrides REFRESH_CYCLES=4 for all scenarios.
- Reset, scan: assert rst, then release -> anode 8'hFE, cathode C0; after 4 clocks anode FD, cathode FF; after 32 clocks back to FE.
- Positive value: value_in=16'sd1234, one-cycle valid -> ready_out low for 17 cycles; digits 0..4 show 99,B0,A4,F9,FF; higher digits FF.
- Negative value: value_in=-1 -> digit0 F9, digit1 BF, others FF.
- Extremes, back to back:
  - value_in=-32768 -> digits 4,5 show B0,BF; lower digits show 8,6,7,2 (80,82,F8,A4).
  - Then 32767 -> digits 0..4 show F8,82,F8,A4,B0, digit5 FF.
- Busy: valid_in held high with 5 then 9 during CONVERT -> only 5 displayed; 9 is accepted only when ready_out returns high.
- Reset mid-conversion: rst after 8 CONVERT cycles of 16'sd4321 -> display "0", ready_out=1 on the next cycle, and the following transfer converts correctly.
